// File: rtl/sim_run_controller.sv
// Run/halt controller with watchdog and a back-pressurable state dump.
// After halt or timeout it drains, then streams the RF followed by DMEM through one read port.
module sim_run_controller #(
  parameter int DATA_W    = 32,
  parameter int RF_AW     = 5,
  parameter int MEM_AW    = 10,
  parameter int DRAIN_CYC = 30,
  parameter int CNT_W     = 32,
  localparam int AW       = (RF_AW > MEM_AW) ? RF_AW : MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic [CNT_W-1:0]  wdog_limit,
  output logic              rd_en,
  output logic              rd_sel,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  output logic [AW-1:0]     out_addr,
  output logic              out_last,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              timeout,
  output logic              done
);

  localparam int DCW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC);
  localparam logic [AW-1:0]  RF_LAST    = AW'({RF_AW{1'b1}});
  localparam logic [AW-1:0]  MEM_LAST   = AW'({MEM_AW{1'b1}});

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_DRAIN = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                done_q, done_d;
  logic [DCW-1:0]      drain_q, drain_d;
  logic                sel_q, sel_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                rd_en_q, rd_en_d;
  logic                valid_q, valid_d;
  logic                fresh_q, fresh_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                handshake;

  assign handshake = valid_q & out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    drain_d   = drain_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    fresh_d   = 1'b0;
    data_d    = fresh_q ? rd_data : data_q;
    last_d    = last_q;

    case (state_q)
      S_RUN: begin
        // halt takes priority over a watchdog hit in the same cycle
        if (halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if ((wdog_limit != '0) && (cnt_q == wdog_limit)) begin
          timeout_d = 1'b1;
          state_d   = S_DRAIN;
          drain_d   = DRAIN_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_ISSUE;
          sel_d   = 1'b0;
          addr_d  = '0;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        valid_d = 1'b1;
        fresh_d = 1'b1;
        last_d  = sel_q && (addr_q == MEM_LAST);
      end

      S_WAIT: begin
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            if (!sel_q && (addr_q == RF_LAST)) begin
              sel_d  = 1'b1;
              addr_d = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    rd_en_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= '0;
      sel_q     <= 1'b0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      drain_q   <= drain_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      valid_q   <= valid_d;
      fresh_q   <= fresh_d;
      data_q    <= data_d;
      last_q    <= last_d;
    end
  end

  // The read port's output register supplies the word in its first valid cycle;
  // data_q keeps it stable for any following back-pressured cycles.
  assign out_data    = fresh_q ? rd_data : data_q;
  assign out_valid   = valid_q;
  assign out_sel     = sel_q;
  assign out_addr    = addr_q;
  assign out_last    = last_q;
  assign rd_en       = rd_en_q;
  assign rd_sel      = sel_q;
  assign rd_addr     = addr_q;
  assign cycle_count = cnt_q;
  assign timeout     = timeout_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: directed and randomized sessions checked against
// a word-list / timing model derived from the run, drain and dump rules.
module tb_sim_run_controller;

  localparam int DW     = 32;
  localparam int RF_AW  = 2;
  localparam int MEM_AW = 2;
  localparam int AW     = 2;
  localparam int CW     = 32;
  localparam int NRF    = 4;
  localparam int NMEM   = 4;
  localparam int NW     = NRF + NMEM;
  localparam int DR0    = 3;
  localparam int DR1    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          halt_v      [2];
  logic [CW-1:0] wdog_v      [2];
  logic          rd_en_v     [2];
  logic          rd_sel_v    [2];
  logic [AW-1:0] rd_addr_v   [2];
  logic [DW-1:0] rd_data_v   [2];
  logic          out_valid_v [2];
  logic          out_ready_v [2];
  logic [DW-1:0] out_data_v  [2];
  logic          out_sel_v   [2];
  logic [AW-1:0] out_addr_v  [2];
  logic          out_last_v  [2];
  logic [CW-1:0] cc_v        [2];
  logic          to_v        [2];
  logic          done_v      [2];

  logic [DW-1:0] rf_m [NRF];
  logic [DW-1:0] dm_m [NMEM];

  int checks   = 0;
  int failures = 0;

  sim_run_controller #(.DATA_W(DW), .RF_AW(RF_AW), .MEM_AW(MEM_AW), .DRAIN_CYC(DR0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .halt(halt_v[0]), .wdog_limit(wdog_v[0]),
    .rd_en(rd_en_v[0]), .rd_sel(rd_sel_v[0]), .rd_addr(rd_addr_v[0]), .rd_data(rd_data_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(out_data_v[0]),
    .out_sel(out_sel_v[0]), .out_addr(out_addr_v[0]), .out_last(out_last_v[0]),
    .cycle_count(cc_v[0]), .timeout(to_v[0]), .done(done_v[0])
  );

  sim_run_controller #(.DATA_W(DW), .RF_AW(RF_AW), .MEM_AW(MEM_AW), .DRAIN_CYC(DR1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .halt(halt_v[1]), .wdog_limit(wdog_v[1]),
    .rd_en(rd_en_v[1]), .rd_sel(rd_sel_v[1]), .rd_addr(rd_addr_v[1]), .rd_data(rd_data_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(out_data_v[1]),
    .out_sel(out_sel_v[1]), .out_addr(out_addr_v[1]), .out_last(out_last_v[1]),
    .cycle_count(cc_v[1]), .timeout(to_v[1]), .done(done_v[1])
  );

  // Synchronous read port: data appears the cycle after rd_en.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en_v[k]) rd_data_v[k] <= rd_sel_v[k] ? dm_m[rd_addr_v[k]] : rf_m[rd_addr_v[k]];
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected k-th dumped word as {sel, addr, last, data}: RF ascending, then DMEM ascending.
  function automatic logic [95:0] exp_word(input int k);
    logic          s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (k < NRF) begin
      s = 1'b0; a = AW'(k); d = rf_m[k];
    end else begin
      s = 1'b1; a = AW'(k - NRF); d = dm_m[k - NRF];
    end
    return 96'({s, a, (k == NW - 1), d});
  endfunction

  function automatic logic [95:0] all_outs(input int di);
    return 96'({rd_en_v[di], rd_sel_v[di], rd_addr_v[di], out_valid_v[di], out_data_v[di],
                out_sel_v[di], out_addr_v[di], out_last_v[di], cc_v[di], to_v[di], done_v[di]});
  endfunction

  task automatic fill_mem(input bit directed);
    for (int i = 0; i < NRF; i++) rf_m[i] = directed ? DW'(32'h10 + i) : DW'($urandom);
    for (int i = 0; i < NMEM; i++) dm_m[i] = directed ? DW'(32'hA0 + i) : DW'($urandom);
  endtask

  // One reset-to-done session. halt_at<0: never halt. rmode 1: random out_ready.
  task automatic session(input int di, input int halt_at, input int wlim, input int rmode,
                         input int stall_word, input int stall_len, input int abort_word);
    int drain, e_cyc, first_rd, first_ov, rd_cnt, words, last_hs, done_first, stall_left, viol;
    bit exp_to, finished, rdy, rv, ov, dn, tov;
    logic [CW-1:0] ccv;
    logic [95:0] got;
    drain = (di == 0) ? DR0 : DR1;
    if (halt_at >= 0 && (wlim == 0 || halt_at <= wlim)) begin
      e_cyc = halt_at; exp_to = 1'b0;
    end else begin
      e_cyc = wlim; exp_to = 1'b1;
    end
    first_rd = -1; first_ov = -1; rd_cnt = 0; words = 0; last_hs = -1; done_first = -1;
    stall_left = stall_len; viol = 0; finished = 1'b0; ccv = '0; tov = 1'b0;

    rst = 1'b1; halt_v[di] = 1'b0; out_ready_v[di] = 1'b0; wdog_v[di] = CW'(wlim);
    @(posedge clk); #1;
    chk("reset_outputs", all_outs(di), 96'd0);
    rst = 1'b0;

    for (int c = 0; c < 600 && !finished; c++) begin
      @(negedge clk);
      rv = rd_en_v[di]; ov = out_valid_v[di]; dn = done_v[di]; ccv = cc_v[di]; tov = to_v[di];
      if (c == 0) chk("count_start", 96'(ccv), 96'd0);
      if (c == e_cyc) chk("count_at_run_end", 96'(ccv), 96'(e_cyc));
      if (c == e_cyc) chk("timeout_before", 96'(tov), 96'd0);
      if (c == e_cyc + 1) chk("timeout_flag", 96'(tov), 96'(exp_to));
      if (rv) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
      end
      if (ov && first_ov < 0) first_ov = c;
      if (dn && done_first < 0) done_first = c;
      if (done_first >= 0 && c == done_first + 2) begin
        chk("done_quiet", 96'({dn, ov, rv}), 96'(3'b100));
        finished = 1'b1;
      end

      if (abort_word >= 0 && ov && words == abort_word) begin
        rst = 1'b1;
        #1;
        chk("abort_reset_outputs", all_outs(di), 96'd0);
        return;
      end

      if (stall_word >= 0 && ov && words == stall_word && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        chk("stall_hold_data", 96'({out_sel_v[di], out_addr_v[di], out_last_v[di], out_data_v[di]}),
            exp_word(words));
        chk("stall_no_rd_en", 96'(rv), 96'd0);
      end else begin
        rdy = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      out_ready_v[di] = rdy;
      if (rv && ov && !rdy) viol++;

      if (halt_at >= 0 && c >= halt_at) halt_v[di] = (c == halt_at) ? 1'b1 : 1'($urandom_range(0, 1));
      else halt_v[di] = 1'b0;

      if (ov && rdy) begin
        got = 96'({out_sel_v[di], out_addr_v[di], out_last_v[di], out_data_v[di]});
        if (words < NW) chk("word", got, exp_word(words));
        else chk("extra_word", 96'(words), 96'(NW - 1));
        words++;
        if (words == NW) last_hs = c;
      end
    end

    chk("dump_finished", 96'(done_first >= 0), 96'd1);
    chk("word_count", 96'(words), 96'(NW));
    chk("rd_en_count", 96'(rd_cnt), 96'(NW));
    chk("first_rd_en", 96'(first_rd), 96'(e_cyc + 2 + drain));
    chk("first_out_valid", 96'(first_ov), 96'(e_cyc + 3 + drain));
    chk("done_latency", 96'(done_first), 96'(last_hs + 1));
    if (rmode == 0 && stall_len == 0)
      chk("last_handshake", 96'(last_hs), 96'(e_cyc + 2 + drain + 2 * NW - 1));
    chk("count_frozen", 96'(ccv), 96'(e_cyc));
    chk("timeout_sticky", 96'(tov), 96'(exp_to));
    chk("rd_en_while_stalled", 96'(viol), 96'd0);
    halt_v[di] = 1'b0;
    out_ready_v[di] = 1'b0;
  endtask

  initial begin
    int h, w;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      halt_v[k] = 1'b0; wdog_v[k] = '0; out_ready_v[k] = 1'b0;
    end
    fill_mem(1'b1);
    #2;
    chk("reset_outputs_dut0", all_outs(0), 96'd0);
    chk("reset_outputs_dut1", all_outs(1), 96'd0);

    session(0, 10, 0, 0, -1, 0, -1);
    session(0, 10, 0, 0, 2, 5, -1);
    fill_mem(1'b0);
    session(0, -1, 20, 1, -1, 0, -1);
    session(0, 20, 20, 0, -1, 0, -1);
    session(0, 12, 0, 0, -1, 0, NRF + 1);
    session(0, int'($urandom_range(0, 15)), 0, 1, -1, 0, -1);
    session(1, 0, 0, 0, -1, 0, -1);

    for (int r = 0; r < 4; r++) begin
      fill_mem(1'b0);
      h = int'($urandom_range(0, 40));
      w = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40));
      session(r % 2, h, w, int'(r % 2), -1, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_run_controller.md
# sim_run_controller

Synthesizable run/halt controller and state-dump sequencer for the pipelined CPU bench. It counts run cycles and applies an optional watchdog. On halt or timeout it waits a configurable drain interval, then walks the register file and data memory through one shared synchronous read port. Each word is streamed out on a valid/ready channel. It replaces fixed-delay bench dumps with a deterministic, back-pressurable dump usable in simulation and on FPGA.

## Interface
- DATA_W, 32, word width of RF and DMEM
- RF_AW, 5, RF address width; 2^RF_AW words dumped
- MEM_AW, 10, DMEM word-address width; 2^MEM_AW words dumped
- DRAIN_CYC, 30, cycles waited after halt/timeout before dumping (0 allowed)
- CNT_W, 32, width of cycle counter and watchdog limit

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- halt  in  1  CPU halt flag; level, sampled each cycle
- wdog_limit  in  CNT_W  watchdog limit in run cycles; 0 disables
- rd_en  out  1  read strobe to dump port
- rd_sel  out  1  0 = RF, 1 = DMEM
- rd_addr  out  max(RF_AW,MEM_AW)  word address; upper bits 0 for RF
- rd_data  in  DATA_W  read data, valid the cycle after rd_en
- out_valid  out  1  dump word available
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_W  dumped word
- out_sel  out  1  region of out_data
- out_addr  out  max(RF_AW,MEM_AW)  address of out_data
- out_last  out  1  high with the final DMEM word
- cycle_count  out  CNT_W  run cycles elapsed; frozen after RUN
- timeout  out  1  sticky; watchdog ended the run
- done  out  1  sticky; dump complete

## Operation
- States: RUN, DRAIN, ISSUE, WAIT, DONE. Reset enters RUN.
- All outputs reset to 0.
- RUN:
  - Run cycles are indexed from 0, the first cycle after reset release.
  - halt=1 in cycle N: cycle_count=N, go to DRAIN.
  - Else, if wdog_limit≠0 and cycle_count==wdog_limit: set timeout, go to DRAIN.
  - Otherwise cycle_count increments (wraps modulo 2^CNT_W).
- If halt and the watchdog condition occur in the same cycle, halt wins and timeout stays 0.
- DRAIN:
  - The down-counter loads DRAIN_CYC on entry and decrements each cycle.
  - Exit to ISSUE (region RF, address 0) when it reads 0. DRAIN_CYC=0 means DRAIN lasts one cycle.
  - halt changes are ignored from DRAIN onward.
- ISSUE:
  - Entered only when out_valid=0, or when the current word is handshaking this cycle.
  - Drives rd_en=1 with the current rd_sel/rd_addr for exactly one cycle, then goes to WAIT.
- WAIT:
  - Captures rd_data, rd_sel, rd_addr into out_data/out_sel/out_addr and sets out_valid.
  - out_last=1 iff region is DMEM and the address is 2^MEM_AW−1.
  - Advances the address. After RF address 2^RF_AW−1 it switches to DMEM address 0.
  - Next state is ISSUE, or DONE-pending after the last word.
- At most one read is outstanding. Maximum throughput is one word per 2 cycles.
- Handshake:
  - A word transfers on a cycle with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data/out_sel/out_addr/out_last hold and no rd_en is issued.
  - out_valid drops after transfer unless a new word is captured the same edge.
- DONE: entered on the handshake of the out_last word. done=1, out_valid=0, rd_en=0. Stays until reset.
- Total words dumped: 2^RF_AW + 2^MEM_AW, RF first, ascending addresses.
- Reset asserted in any state:
  - Immediately (asynchronously) clears all outputs and state, including mid-dump.
  - After release, the controller restarts in RUN with cycle_count=0.

## Timing
- halt high in run cycle N → DRAIN occupies cycles N+1..N+1+DRAIN_CYC.
- First rd_en is in cycle N+2+DRAIN_CYC.
- First out_valid is at N+3+DRAIN_CYC.
- With out_ready held high, words appear every 2 cycles. The last handshake is at N+2+DRAIN_CYC+2·(2^RF_AW+2^MEM_AW)−1.
- done rises the cycle after the last handshake.
- timeout rises the cycle after cycle_count reaches wdog_limit.
- rd_en, out_* are registered outputs; no combinational path from out_ready to out_valid.

## Test plan
- RF_AW=2, MEM_AW=2, DRAIN_CYC=3, halt at cycle 10, out_ready=1, RF words 0x10..0x13, DMEM words 0xA0..0xA3:
  - cycle_count=10, timeout=0.
  - First rd_en at cycle 15.
  - 8 words in order RF0..RF3, MEM0..MEM3 with matching out_sel/out_addr.
  - out_last only on 0xA3; done=1 one cycle after its handshake.
- Same setup, out_ready=0 for 5 cycles while word 2 is valid → out_data=0x12 held stable, rd_en=0 throughout, no word lost or duplicated.
- halt never asserted, wdog_limit=20 → timeout=1, cycle_count=20, full dump follows, done=1.
- halt=1 exactly in cycle 20 with wdog_limit=20 → timeout=0, cycle_count=20.
- rst pulsed while dumping DMEM word 1 → all outputs 0 immediately; after release, state is RUN, cycle_count counts from 0, and a later halt produces a full dump from RF0.
- DRAIN_CYC=0, wdog_limit=0, halt at cycle 0 → DRAIN lasts one cycle, first rd_en at cycle 2, watchdog never fires.
